cpu_io_stream_bridge: RTL
=========================

Name: cpu_io_stream_bridge

Overview:
Parametrised successor to the fixed 4-bit operand/result pass BELs in the W_CPU_IO tile. It moves operand words from the CPU into the fabric and result words from the fabric back to the CPU. Channel count, channel width and buffering depth are generic. Each direction is either a legacy registered pass-through or a valid/ready FIFO stream, selected by configuration bits.

Parameters:
OP_CHANNELS, 2, number of operand channels (CPU->fabric)
RES_CHANNELS, 3, number of result channels (fabric->CPU)
CH_WIDTH, 4, bits per channel
FIFO_DEPTH, 4, entries per direction; power of 2, >=2
NoConfigBits, 2, configuration bits consumed (fixed at 2)

Ports:
UserCLK  input  1  fabric user clock; sole clock
reset  input  1  synchronous, active-high reset
ConfigBits  input  NoConfigBits  [0]=operand mode, [1]=result mode; 0=bypass, 1=stream
op_data  input  OP_CHANNELS*CH_WIDTH  CPU operand word
op_valid  input  1  CPU operand valid
op_ready  output  1  bridge can accept operand
fab_op_data  output  OP_CHANNELS*CH_WIDTH  operand word to fabric
fab_op_valid  output  1  fab_op_data valid
fab_op_ready  input  1  fabric takes operand
fab_res_data  input  RES_CHANNELS*CH_WIDTH  fabric result word
fab_res_valid  input  1  fabric result valid
fab_res_ready  output  1  bridge can accept result
res_data  output  RES_CHANNELS*CH_WIDTH  result word to CPU
res_valid  output  1  res_data valid
res_ready  input  1  CPU takes result
op_level  output  $clog2(FIFO_DEPTH)+1  operand entries held
res_level  output  $clog2(FIFO_DEPTH)+1  result entries held

Behaviour:
- Clock and reset: UserCLK only. Reset is synchronous and active-high. While reset is high at a clock edge, every output is driven to 0 on that edge: ready, valid, data and level. The first cycle after reset deasserts, both ready outputs are 1.
- The two directions are identical and independent. Source side is (data, valid, ready-out). Sink side is (data, valid-out, ready-in).
- Push means valid && ready at an edge. Pop means valid-out && ready-in at an edge.
- Stream mode (ConfigBits bit = 1):
  - Circular FIFO with FIFO_DEPTH entries.
  - First-word-fall-through: a word pushed at edge N appears on the sink with valid-out = 1 after edge N. Latency is 1 cycle.
  - Source ready = (level < FIFO_DEPTH), registered. It has no combinational dependence on ready-in.
  - Full with push and pop in the same cycle: the push is refused (ready already 0); the pop completes; level becomes FIFO_DEPTH-1.
  - Empty with push in the same cycle: the push completes, no pop occurs, level becomes 1.
  - Otherwise, simultaneous push and pop leaves level unchanged and keeps word order.
  - Pointers wrap modulo FIFO_DEPTH. level = number of words held, in the range 0..FIFO_DEPTH.
  - Sink data is held stable while valid-out = 1 and ready-in = 0.
- Bypass mode (ConfigBits bit = 0), equivalent to the legacy registered pass:
  - Source ready is constantly 1.
  - On every edge, the output data register loads source data and valid-out loads source valid. ready-in is ignored.
  - level = valid-out (0 or 1).
- Mode change: when a ConfigBits bit differs from its value on the previous edge, that direction flushes on that edge. Pointers and level go to 0, valid-out goes to 0, and the word on the source at that edge is discarded. Stream-mode ready returns to 1 on the next cycle. The other direction is unaffected.
- Reset asserted mid-transfer discards all held words. No partial word is ever emitted.
- Data width: word = CHANNELS*CH_WIDTH bits. Channel k occupies bits [k*CH_WIDTH +: CH_WIDTH]. No arithmetic is performed on data.

Test Plan:
- Reset and fill: reset 2 cycles, stream mode, FIFO_DEPTH=4. Push 0x11,0x22,0x33,0x44 on back-to-back cycles with fab_op_ready=0 -> op_level counts 1,2,3,4; op_ready=0 after the 4th push; fab_op_data=0x11 throughout.
- Full with simultaneous push and pop: while full, op_valid=1 with 0x55 and fab_op_ready=1 for one cycle -> 0x11 popped, 0x55 refused, op_level=3; the next cycle accepts 0x55. Drain order is 0x22,0x33,0x44,0x55.
- Wrap-around and throughput: stream 20 consecutive results 0x001..0x014 with res_ready=1 -> one word per cycle after a 1-cycle latency, res_level stays at 1, no gaps or reordering across pointer wrap.
- Bypass mode: ConfigBits=00. Drive op_data=0xA5, op_valid=1 with fab_op_ready=0 -> fab_op_data=0xA5 and fab_op_valid=1 one cycle later; op_ready is always 1; dropping op_valid clears fab_op_valid the next cycle.
- Mode-change flush: res FIFO holds 3 words; flip ConfigBits[1] from 1 to 0 -> res_level=0 and res_valid=0 after that edge; the operand FIFO contents are untouched.
- Mid-operation reset: with op_level=2 and res_level=3, pulse reset for 1 cycle -> all outputs 0 on that edge; after reset both levels=0, op_ready=1 and fab_res_ready=1; the old words never reappear.

Source files
------------

// File: rtl/cpu_io_stream_bridge.sv
// cpu_io_stream_bridge: CPU<->fabric operand/result transfer, each direction a registered pass or FWFT FIFO.
module cpu_io_stream_lane #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [W-1:0]             src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [W-1:0]             snk_data,
  output logic                     snk_valid,
  input  logic                     snk_ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] level_n;
  logic mode_q, push, pop;
  assign push = src_valid && src_ready;
  assign pop = snk_valid && snk_ready;
  assign level_n = level + (AW+1)'(push) - (AW+1)'(pop);
  assign snk_valid = level != '0;
  assign snk_data = mem[rd];
  // Bypass reuses slot 0 as the legacy output register; pointers stay at 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      level <= '0;
      src_ready <= 1'b0;
      mode_q <= mode;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        wr <= '0;
        rd <= '0;
        level <= '0;
        src_ready <= 1'b1;
      end else if (!mode) begin
        mem[0] <= src_data;
        level <= {{AW{1'b0}}, src_valid};
        src_ready <= 1'b1;
      end else begin
        if (push) begin
          mem[wr] <= src_data;
          wr <= wr + AW'(1);
        end
        if (pop) rd <= rd + AW'(1);
        level <= level_n;
        src_ready <= level_n != (AW+1)'(DEPTH);
      end
    end
  end
endmodule

module cpu_io_stream_bridge #(
  parameter int OP_CHANNELS = 2,
  parameter int RES_CHANNELS = 3,
  parameter int CH_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                               UserCLK,
  input  logic                               reset,
  input  logic [NoConfigBits-1:0]            ConfigBits,
  input  logic [OP_CHANNELS*CH_WIDTH-1:0]    op_data,
  input  logic                               op_valid,
  output logic                               op_ready,
  output logic [OP_CHANNELS*CH_WIDTH-1:0]    fab_op_data,
  output logic                               fab_op_valid,
  input  logic                               fab_op_ready,
  input  logic [RES_CHANNELS*CH_WIDTH-1:0]   fab_res_data,
  input  logic                               fab_res_valid,
  output logic                               fab_res_ready,
  output logic [RES_CHANNELS*CH_WIDTH-1:0]   res_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [$clog2(FIFO_DEPTH):0]        op_level,
  output logic [$clog2(FIFO_DEPTH):0]        res_level
);
  cpu_io_stream_lane #(.W(OP_CHANNELS*CH_WIDTH), .DEPTH(FIFO_DEPTH)) u_op (
    .clk(UserCLK), .rst(reset), .mode(ConfigBits[0]),
    .src_data(op_data), .src_valid(op_valid), .src_ready(op_ready),
    .snk_data(fab_op_data), .snk_valid(fab_op_valid), .snk_ready(fab_op_ready),
    .level(op_level)
  );
  cpu_io_stream_lane #(.W(RES_CHANNELS*CH_WIDTH), .DEPTH(FIFO_DEPTH)) u_res (
    .clk(UserCLK), .rst(reset), .mode(ConfigBits[1]),
    .src_data(fab_res_data), .src_valid(fab_res_valid), .src_ready(fab_res_ready),
    .snk_data(res_data), .snk_valid(res_valid), .snk_ready(res_ready),
    .level(res_level)
  );
endmodule
